// File: rtl/serial_twos_comp_array.sv
// Multi-lane bit-serial two's-complement negator (LSB first, shared framing).
// Optional parallel word output is compiled in with `define PAR_OUT_EN.
module serial_twos_comp_array #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                t_clk,
  input  logic                r_n,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [CHANNELS-1:0] neg_en,
  input  logic [CHANNELS-1:0] in_bit,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_bit,
  output logic                out_eow,
  output logic [CHANNELS-1:0] ovf,
  output logic                frm_err
`ifdef PAR_OUT_EN
  ,
  output logic                      par_valid,
  output logic [CHANNELS*WIDTH-1:0] par_word
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [CHANNELS-1:0] seen, seen_n;
  logic [CHANNELS-1:0] mode, mode_n;

  logic                accept, last, err;
  logic [CHANNELS-1:0] cur_mode, cur_seen, conv, ovf_v;

  // cnt holds the index of the next expected bit while in RUN
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    seen_n   = seen;
    mode_n   = mode;
    accept   = 1'b0;
    last     = 1'b0;
    err      = 1'b0;
    cur_mode = mode;
    cur_seen = seen;
    if (in_valid) begin
      if (in_sof) begin
        accept   = 1'b1;
        err      = (state == RUN);
        cur_mode = neg_en;
        cur_seen = '0;
        mode_n   = neg_en;
        state_n  = RUN;
        cnt_n    = CW'(1);
      end else if (state == RUN) begin
        accept = 1'b1;
        last   = (cnt == LAST);
        if (last) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end else begin
        err = 1'b1;
      end
    end
    conv  = in_bit ^ (cur_mode & cur_seen);
    ovf_v = last ? (cur_mode & in_bit & ~cur_seen) : '0;
    if (accept) seen_n = cur_seen | in_bit;
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state     <= IDLE;
      cnt       <= '0;
      seen      <= '0;
      mode      <= '0;
      out_valid <= 1'b0;
      out_bit   <= '0;
      out_eow   <= 1'b0;
      ovf       <= '0;
      frm_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      seen      <= seen_n;
      mode      <= mode_n;
      out_valid <= accept;
      out_bit   <= accept ? conv : '0;
      out_eow   <= last;
      ovf       <= ovf_v;
      frm_err   <= err;
    end
  end

`ifdef PAR_OUT_EN
  // sh holds the WIDTH-1 most recent converted bits; the final bit completes the word
  logic [WIDTH-2:0] sh  [CHANNELS];
  logic [WIDTH-1:0] col [CHANNELS];

  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      col[k] = {conv[k], sh[k]};
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      for (int unsigned k = 0; k < CHANNELS; k++) sh[k] <= '0;
      par_valid <= 1'b0;
      par_word  <= '0;
    end else begin
      par_valid <= last;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (accept) sh[k] <= col[k][WIDTH-1:1];
        if (last) par_word[k*WIDTH +: WIDTH] <= col[k];
      end
    end
  end
`endif

endmodule
